mem_ctrl: RTL and testbench

Bus master for the 8-entry, 256-bit tristate-bus memory. Accepts single read/write requests from the matrix datapath over a valid/ready handshake and sequences `nEnable`, `ReadWrite`, `address` and the shared `dataBus` so that the memory sees legal read and write cycles. Read data and write completions are returned as one-cycle pulses. The block owns bus turnaround, so the datapath never touches the tristate bus directly.

---
 rtl/mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: bus master for the 8-word, 256-bit tristate-bus memory.
// Takes one read or write request at a time over valid/ready. It sequences
// nEnable, ReadWrite, address and the shared dataBus into legal memory cycles.
// Completions come back as one-cycle pulses. This block owns bus turnaround,
// so only the WRITE state ever drives the bus.
module mem_ctrl #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              err,
    output logic [7:0]        rd_count,
    output logic [7:0]        wr_count,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic [ADDR_W-1:0] address,
    output logic              nEnable,
    output logic              ReadWrite
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        RD_FETCH  = 3'd2,
        RD_RETURN = 3'd3,
        TURN      = 3'd4
    } ctrlState_t;

    ctrlState_t        state;
    ctrlState_t        stateNext;
    logic [DATA_W-1:0] writeData;
    logic              busDrive;
    logic              accept;
    logic              addrInRange;

    // Ready only in IDLE, and forced low while reset is held.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Widen both sides so the range test stays correct for any ADDR_W/DEPTH mix.
    assign addrInRange = 32'(req_addr) < 32'(DEPTH);

    // State register; reset aborts any cycle in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode: every access ends in TURN so the bus is released.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!addrInRange) begin
                        stateNext = TURN;
                    end else if (req_write) begin
                        stateNext = WRITE;
                    end else begin
                        stateNext = RD_FETCH;
                    end
                end
            end
            WRITE:     stateNext = TURN;
            RD_FETCH:  stateNext = RD_RETURN;
            RD_RETURN: stateNext = TURN;
            TURN:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Memory strobes decoded purely from the registered state.
    // RD_RETURN drops ReadWrite so the memory drives its latched word.
    always_comb begin
        nEnable   = 1'b1;
        ReadWrite = 1'b1;
        busDrive  = 1'b0;
        case (state)
            WRITE: begin
                nEnable   = 1'b0;
                ReadWrite = 1'b0;
                busDrive  = 1'b1;
            end
            RD_FETCH: begin
                nEnable   = 1'b0;
                ReadWrite = 1'b1;
            end
            RD_RETURN: begin
                nEnable   = 1'b0;
                ReadWrite = 1'b0;
            end
            default: begin
                nEnable   = 1'b1;
                ReadWrite = 1'b1;
            end
        endcase
    end

    // Only WRITE drives the shared bus. Reset returns state to IDLE, which releases it.
    assign dataBus = busDrive ? writeData : {DATA_W{1'bz}};

    // Capture the request at acceptance. Error requests leave address untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address   <= '0;
            writeData <= '0;
        end else if (accept && addrInRange) begin
            address <= req_addr;
            if (req_write) begin
                writeData <= req_wdata;
            end
        end
    end

    // Completion and error pulses. Each is raised by a single state or event,
    // so the three pulses are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            wr_done  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            err      <= accept && !addrInRange;
            wr_done  <= (state == WRITE);
            rd_valid <= (state == RD_RETURN);
        end
    end

    // Read data is sampled from the memory-driven bus at the end of RD_RETURN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (state == RD_RETURN) begin
            rd_data <= dataBus;
        end
    end

    // Completion counters wrap naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= 8'd0;
            wr_count <= 8'd0;
        end else begin
            if (state == WRITE) begin
                wr_count <= wr_count + 8'd1;
            end
            if (state == RD_RETURN) begin
                rd_count <= rd_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized requests against mem_ctrl.
// A bus-level memory device model answers the controller. Expected results
// come from a word-array reference plus completion counters and the
// per-request latencies.
module tb_mem_ctrl;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [3:0]   req_addr;
    logic [255:0] req_wdata;
    logic [255:0] rd_data;
    logic         rd_valid;
    logic         wr_done;
    logic         err;
    logic [7:0]   rd_count;
    logic [7:0]   wr_count;
    wire  [255:0] dataBus;
    logic [3:0]   address;
    logic         nEnable;
    logic         ReadWrite;

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_done   (wr_done),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .dataBus   (dataBus),
        .address   (address),
        .nEnable   (nEnable),
        .ReadWrite (ReadWrite)
    );

    always #5 clk = ~clk;

    // Memory device: it latches a word at a posedge with nEnable=0 and ReadWrite=1.
    // It then drives that word while ReadWrite=0. It writes whatever is on the
    // bus at the negedge when nEnable=0 and ReadWrite=0.
    logic [255:0] memArr [8];
    logic [255:0] memOut;
    logic         memLatched = 1'b0;

    assign dataBus = (memLatched && !nEnable && !ReadWrite) ? memOut : {256{1'bz}};

    always @(posedge clk) begin
        memLatched <= !nEnable && ReadWrite;
        if (!nEnable && ReadWrite) memOut <= memArr[address[2:0]];
    end

    always @(negedge clk) begin
        if (!nEnable && !ReadWrite) memArr[address[2:0]] <= dataBus;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and bookkeeping.
    logic [255:0] expMem [8];
    int  expWr = 0;
    int  expRd = 0;
    int  passed = 0;
    int  total = 0;
    int  lastAccept = 0;
    int  prevGap = 0;
    bit  havePrev = 1'b0;
    logic [255:0] pat [8];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chkW(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // True when no driver asserts a 1 or an X on the bus.
    function automatic logic released(input logic [255:0] v);
        for (int i = 0; i < 256; i++) begin
            if (v[i] !== 1'b0 && v[i] !== 1'bz) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request. Called at an observation point 1ns after a posedge.
    // chain=1 keeps req_valid high after acceptance.
    task automatic runReq(input bit w, input logic [3:0] a, input logic [255:0] d, input bit chain);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk1("ready_wait", req_ready, 1'b1);
        step();
        if (havePrev) chk8("accept_gap", 8'(cyc - lastAccept), 8'(prevGap));
        lastAccept = cyc;
        havePrev = 1'b1;
        if (!chain) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 4'($urandom);
            req_wdata = rand256();
        end
        if (int'(a) >= DEPTH) begin
            chk1("err_pulse", err, 1'b1);
            chk1("err_nen", nEnable, 1'b1);
            chk1("err_no_wrdone", wr_done, 1'b0);
            chk8("err_wrcnt", wr_count, 8'(expWr));
            chk8("err_rdcnt", rd_count, 8'(expRd));
            step();
            chk1("err_clear", err, 1'b0);
            chk1("err_nen2", nEnable, 1'b1);
            chk1("err_ready", req_ready, 1'b1);
            prevGap = 2;
            $display("req err   addr=%0d", a);
        end else if (w) begin
            chk1("wr_nen", nEnable, 1'b0);
            chk1("wr_rw", ReadWrite, 1'b0);
            chk4("wr_addr", address, a);
            chkW("wr_bus", dataBus, d);
            chk1("wr_done_early", wr_done, 1'b0);
            chk1("wr_busy", req_ready, 1'b0);
            step();
            expWr++;
            expMem[a[2:0]] = d;
            chk1("wr_done", wr_done, 1'b1);
            chk8("wr_count", wr_count, 8'(expWr));
            chk1("wr_turn_nen", nEnable, 1'b1);
            chk1("wr_turn_rel", released(dataBus), 1'b1);
            step();
            chk1("wr_ready", req_ready, 1'b1);
            chk1("wr_done_clear", wr_done, 1'b0);
            prevGap = 3;
            $display("req write addr=%0d wr_count=%0d", a, wr_count);
        end else begin
            chk1("rd_fetch_nen", nEnable, 1'b0);
            chk1("rd_fetch_rw", ReadWrite, 1'b1);
            chk4("rd_fetch_addr", address, a);
            chk1("rd_fetch_rel", released(dataBus), 1'b1);
            step();
            chk1("rd_ret_nen", nEnable, 1'b0);
            chk1("rd_ret_rw", ReadWrite, 1'b0);
            chk1("rd_valid_early", rd_valid, 1'b0);
            step();
            expRd++;
            chk1("rd_valid", rd_valid, 1'b1);
            chkW("rd_data", rd_data, expMem[a[2:0]]);
            chk8("rd_count", rd_count, 8'(expRd));
            chk1("rd_turn_nen", nEnable, 1'b1);
            chk1("rd_turn_rel", released(dataBus), 1'b1);
            step();
            chk1("rd_ready", req_ready, 1'b1);
            chk1("rd_valid_clear", rd_valid, 1'b0);
            chkW("rd_hold", rd_data, expMem[a[2:0]]);
            prevGap = 4;
            $display("req read  addr=%0d rd_count=%0d", a, rd_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 4'd0;
        req_wdata = '0;
        #2;
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_nen", nEnable, 1'b1);
        chk1("rst_rw", ReadWrite, 1'b1);
        chk4("rst_addr", address, 4'd0);
        chkW("rst_rdata", rd_data, '0);
        chk1("rst_rvalid", rd_valid, 1'b0);
        chk1("rst_wrdone", wr_done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk8("rst_rdcnt", rd_count, 8'd0);
        chk8("rst_wrcnt", wr_count, 8'd0);
        chk1("rst_bus", released(dataBus), 1'b1);
        @(posedge clk);
        #4;
        rst = 1'b0;
        step();

        // Basic write then read of address 3.
        runReq(1'b1, 4'd3, {32{8'hA5}}, 1'b0);
        runReq(1'b0, 4'd3, rand256(), 1'b0);

        // Fill all words, then read them back, with req_valid held high.
        havePrev = 1'b0;
        for (int i = 0; i < 8; i++) pat[i] = rand256();
        for (int i = 0; i < 8; i++) runReq(1'b1, 4'(i), pat[i], 1'b1);
        for (int i = 0; i < 8; i++) runReq(1'b0, 4'(i), rand256(), 1'b1);
        req_valid = 1'b0;

        // Out-of-range addresses.
        runReq(1'b0, 4'd8, rand256(), 1'b0);
        runReq(1'b1, 4'd15, rand256(), 1'b0);

        // Random mix of reads, writes and errors.
        for (int i = 0; i < 40; i++) begin
            runReq(1'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                   rand256(), 1'($urandom));
        end
        req_valid = 1'b0;

        // Reset during RD_RETURN aborts the read.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 4'd3;
        step();
        chk1("abort_accept", req_ready, 1'b0);
        req_valid = 1'b0;
        step();
        chk1("abort_pre_nen", nEnable, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expRd = 0;
        expWr = 0;
        chk1("abort_nen", nEnable, 1'b1);
        chk1("abort_rw", ReadWrite, 1'b1);
        chk1("abort_bus", released(dataBus), 1'b1);
        chk1("abort_ready", req_ready, 1'b0);
        chk1("abort_rvalid", rd_valid, 1'b0);
        step();
        chk1("abort_no_rvalid", rd_valid, 1'b0);
        chk8("abort_rdcnt", rd_count, 8'd0);
        chkW("abort_rdata", rd_data, '0);
        #3;
        rst = 1'b0;
        step();
        $display("reset during read-return applied and released");
        havePrev = 1'b0;
        runReq(1'b0, 4'd3, rand256(), 1'b0);

        // 256 writes wrap the write counter; reads are unaffected.
        for (int i = 0; i < 256; i++) runReq(1'b1, 4'($urandom_range(0, 7)), rand256(), 1'b1);
        req_valid = 1'b0;
        chk8("wr_wrap", wr_count, 8'd0);
        chk8("rd_after_wrap", rd_count, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
